// File: rtl/inpfifo_pkg.sv
// Shared definitions for the input lane packer and its word FIFO.
package inpfifo_pkg;

    localparam int DIN_W_DEF = 8;
    localparam int LANES_DEF = 2;
    localparam int DEPTH_DEF = 16;
    localparam int LANES_MAX = 8;

    // Lane index: wide enough for up to LANES_MAX lanes (0..7).
    typedef logic [2:0] lane_idx_t;

    // Ceiling log2, usable in constant expressions (port widths, localparams).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/inpfifo_pack_fifo.sv
// First-word-fall-through synchronous FIFO: storage, pointers and level.
// Writes while full and reads while empty are ignored; clr_i empties it.
module sync_fifo_fwft
    import inpfifo_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               wr_en_i,
    input  logic [WIDTH-1:0]   wr_data_i,
    input  logic               rd_en_i,
    output logic [WIDTH-1:0]   rd_data_o,
    output logic               empty_o,
    output logic               full_o,
    output logic [clog2(DEPTH):0] level_o
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             wr_ok, rd_ok;
    logic [WIDTH-1:0] mem [DEPTH];

    assign empty_o   = (level_q == '0);
    assign full_o    = (level_q == LW'(DEPTH));
    assign level_o   = level_q;
    assign rd_data_o = mem[rptr_q];

    // Next pointers/level; a full FIFO refuses writes even if popping this cycle.
    always_comb begin
        wr_ok   = wr_en_i && !full_o && !clr_i;
        rd_ok   = rd_en_i && !empty_o && !clr_i;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (clr_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (wr_ok) wptr_d = wptr_q + AW'(1);
            if (rd_ok) rptr_d = rptr_q + AW'(1);
            level_d = level_q + LW'(wr_ok) - LW'(rd_ok);
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/inpfifo_pack.sv
// Packs LANES narrow input beats into one wide word and queues it in a FWFT
// FIFO. A completed word is registered first and written one edge later.
module inpfifo_pack
    import inpfifo_pkg::*;
#(
    parameter int DIN_W     = DIN_W_DEF,
    parameter int LANES     = LANES_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int MSB_FIRST = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DIN_W-1:0]       din,
    input  logic                   din_vld,
    input  logic                   din_sof,
    input  logic                   flush,
    input  logic                   ovf_clr,
    input  logic                   fifo_rd,
    output logic [DIN_W*LANES-1:0] fifo_q,
    output logic                   fifo_empty,
    output logic                   fifo_full,
    output logic [clog2(DEPTH):0]  fifo_level,
    output logic                   fifo_ovf
);

    localparam lane_idx_t LAST_LANE = lane_idx_t'(LANES - 1);

    logic [LANES-1:0][DIN_W-1:0] acc_q, acc_d;
    logic [DIN_W*LANES-1:0]      packed_w, word_q;
    lane_idx_t                   cnt_q, cnt_d;
    logic                        pend_q, pend_d;
    logic                        ovf_q, ovf_d;
    logic                        fifo_wr;

    // Lane collection: flush beats sof, sof restarts the word at lane 0.
    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        pend_d = 1'b0;
        if (flush) begin
            cnt_d = '0;
        end else if (din_vld && din_sof) begin
            acc_d[0] = din;
            cnt_d    = lane_idx_t'(1);
        end else if (din_vld) begin
            for (int k = 0; k < LANES; k++) begin
                if (cnt_q == lane_idx_t'(k)) acc_d[k] = din;
            end
            if (cnt_q == LAST_LANE) begin
                cnt_d  = '0;
                pend_d = 1'b1;
            end else begin
                cnt_d = cnt_q + lane_idx_t'(1);
            end
        end
    end

    // Lane placement in the output word: ascending or mirrored.
    always_comb begin
        packed_w = '0;
        for (int k = 0; k < LANES; k++) begin
            if (MSB_FIRST != 0) packed_w[(LANES-1-k)*DIN_W +: DIN_W] = acc_d[k];
            else                packed_w[k*DIN_W +: DIN_W]           = acc_d[k];
        end
    end

    // Sticky overflow: a registered word meeting a full FIFO; set beats clear.
    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (pend_q && !flush && fifo_full) ovf_d = 1'b1;
    end

    // Control state: lane counter, pending-write flag, overflow flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    // Data path registers: partial lanes and the completed word awaiting write.
    always_ff @(posedge clk) begin
        acc_q <= acc_d;
        if (pend_d) word_q <= packed_w;
    end

    // A flush at the write edge drops the pending word.
    assign fifo_wr  = pend_q && !flush;
    assign fifo_ovf = ovf_q;

    sync_fifo_fwft #(
        .WIDTH (DIN_W*LANES),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (flush),
        .wr_en_i   (fifo_wr),
        .wr_data_i (word_q),
        .rd_en_i   (fifo_rd),
        .rd_data_o (fifo_q),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full),
        .level_o   (fifo_level)
    );

endmodule

// File: tb/tb_inpfifo_pack.sv
// Bench for inpfifo_pack: directed scenarios plus a long random run against
// a queue-based reference model of the packer and FIFO.
module tb_inpfifo_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  din = '0;
    logic        din_vld = 1'b0, din_sof = 1'b0, flush = 1'b0, ovf_clr = 1'b0, fifo_rd = 1'b0;
    logic [15:0] fifo_q;
    logic        fifo_empty, fifo_full, fifo_ovf;
    logic [4:0]  fifo_level;

    logic [7:0]  b_din = '0;
    logic        b_vld = 1'b0, b_sof = 1'b0, b_zero = 1'b0;
    logic [31:0] b_q;
    logic        b_empty, b_full, b_ovf;
    logic [4:0]  b_level;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [15:0] mq[$];
    logic [7:0]  part[$];
    bit          pend;
    logic [15:0] pword;
    bit          movf;

    always #5 clk = ~clk;

    inpfifo_pack dut (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_sof(din_sof),
        .flush(flush), .ovf_clr(ovf_clr), .fifo_rd(fifo_rd), .fifo_q(fifo_q),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_level(fifo_level),
        .fifo_ovf(fifo_ovf)
    );

    inpfifo_pack #(.DIN_W(8), .LANES(4), .DEPTH(16), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .din(b_din), .din_vld(b_vld), .din_sof(b_sof),
        .flush(b_zero), .ovf_clr(b_zero), .fifo_rd(b_zero), .fifo_q(b_q),
        .fifo_empty(b_empty), .fifo_full(b_full), .fifo_level(b_level),
        .fifo_ovf(b_ovf)
    );

    // Behavioural model of one clock edge, from the pre-edge state.
    function automatic void model_step(input bit vld, input bit sof, input logic [7:0] d,
                                       input bit rd, input bit fl, input bit clr);
        bit was_empty, was_full;
        if (clr) movf = 1'b0;
        if (fl) begin
            mq.delete();
            part.delete();
            pend = 1'b0;
            return;
        end
        was_empty = (mq.size() == 0);
        was_full  = (mq.size() >= 16);
        if (rd && !was_empty) void'(mq.pop_front());
        if (pend) begin
            if (was_full) movf = 1'b1;
            else          mq.push_back(pword);
        end
        pend = 1'b0;
        if (vld) begin
            if (sof) part.delete();
            part.push_back(d);
            if (!sof && part.size() == 2) begin
                pword = {part[1], part[0]};
                pend  = 1'b1;
                part.delete();
            end
        end
    endfunction

    task automatic cyc(input bit vld, input bit sof, input logic [7:0] d,
                       input bit rd, input bit fl, input bit clr);
        @(negedge clk);
        rst = 1'b1; din_vld = vld; din_sof = sof; din = d;
        fifo_rd = rd; flush = fl; ovf_clr = clr;
        b_vld = 1'b0; b_sof = 1'b0;
        model_step(vld, sof, d, rd, fl, clr);
        @(posedge clk); #1;
    endtask

    task automatic cyc2(input bit vld, input logic [7:0] d);
        @(negedge clk);
        rst = 1'b1; din_vld = 1'b0; din_sof = 1'b0; fifo_rd = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
        b_vld = vld; b_sof = 1'b0; b_din = d;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; din_vld = 1'b0; din_sof = 1'b0; fifo_rd = 1'b0; flush = 1'b0;
        ovf_clr = 1'b0; b_vld = 1'b0; b_sof = 1'b0;
        @(posedge clk); #1;
        mq.delete(); part.delete(); pend = 1'b0; movf = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || fifo_level !== 5'd0 || fifo_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset: empty=%b full=%b level=%0d ovf=%b, want 1 0 0 0",
                     fifo_empty, fifo_full, fifo_level, fifo_ovf);
        end
        checks++;
        if (b_empty !== 1'b1 || b_level !== 5'd0) begin
            errors++;
            $display("FAIL reset_msb: empty=%b level=%0d, want 1 0", b_empty, b_level);
        end
    endtask

    task automatic test_pack();
        do_reset();
        cyc(1, 0, 8'h01, 0, 0, 0);
        cyc(1, 0, 8'h02, 0, 0, 0);
        checks++;
        if (fifo_empty !== 1'b1) begin
            errors++; $display("FAIL pack_latency: empty=%b one edge after completion, want 1", fifo_empty);
        end
        cyc(1, 0, 8'h03, 0, 0, 0);
        checks++;
        if (fifo_empty !== 1'b0 || fifo_q !== 16'h0201 || fifo_level !== 5'd1) begin
            errors++; $display("FAIL pack_first: empty=%b q=%h level=%0d, want 0 0201 1", fifo_empty, fifo_q, fifo_level);
        end
        cyc(1, 0, 8'h04, 0, 0, 0);
        cyc(0, 0, 8'h00, 0, 0, 0);
        checks++;
        if (fifo_level !== 5'd2 || fifo_q !== 16'h0201) begin
            errors++; $display("FAIL pack_two: level=%0d q=%h, want 2 0201", fifo_level, fifo_q);
        end
        cyc(0, 0, 8'h00, 1, 0, 0);
        checks++;
        if (fifo_level !== 5'd1 || fifo_q !== 16'h0403) begin
            errors++; $display("FAIL pack_pop: level=%0d q=%h, want 1 0403", fifo_level, fifo_q);
        end
        cyc(0, 0, 8'h00, 1, 0, 0);
        cyc(0, 0, 8'h00, 1, 0, 0);
        checks++;
        if (fifo_empty !== 1'b1 || fifo_level !== 5'd0) begin
            errors++; $display("FAIL pop_on_empty: empty=%b level=%0d, want 1 0", fifo_empty, fifo_level);
        end
    endtask

    task automatic test_empty_write_read();
        do_reset();
        cyc(1, 0, 8'h55, 0, 0, 0);
        cyc(1, 0, 8'h66, 0, 0, 0);
        cyc(0, 0, 8'h00, 1, 0, 0);
        checks++;
        if (fifo_level !== 5'd1 || fifo_q !== 16'h6655) begin
            errors++; $display("FAIL empty_wr_rd: level=%0d q=%h, want 1 6655", fifo_level, fifo_q);
        end
    endtask

    task automatic test_sof();
        do_reset();
        cyc(1, 0, 8'h11, 0, 0, 0);
        cyc(1, 1, 8'h22, 0, 0, 0);
        cyc(0, 0, 8'h00, 0, 0, 0);
        checks++;
        if (fifo_empty !== 1'b1) begin
            errors++; $display("FAIL sof_drop: empty=%b, want 1", fifo_empty);
        end
        cyc(1, 0, 8'h33, 0, 0, 0);
        cyc(0, 0, 8'h00, 0, 0, 0);
        checks++;
        if (fifo_level !== 5'd1 || fifo_q !== 16'h3322) begin
            errors++; $display("FAIL sof_word: level=%0d q=%h, want 1 3322", fifo_level, fifo_q);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 32; i++) cyc(1, 0, 8'(i + 1), 0, 0, 0);
        cyc(1, 0, 8'hE0, 0, 0, 0);
        cyc(1, 0, 8'hE1, 0, 0, 0);
        cyc(0, 0, 8'h00, 0, 0, 0);
        checks++;
        if (fifo_full !== 1'b1 || fifo_level !== 5'd16 || fifo_ovf !== 1'b1 || fifo_q !== 16'h0201) begin
            errors++; $display("FAIL overflow: full=%b level=%0d ovf=%b q=%h, want 1 16 1 0201",
                               fifo_full, fifo_level, fifo_ovf, fifo_q);
        end
        cyc(0, 0, 8'h00, 0, 0, 1);
        checks++;
        if (fifo_ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_clr: ovf=%b, want 0", fifo_ovf);
        end
        // overflow and clear in the same cycle: set wins
        cyc(1, 0, 8'hE2, 0, 0, 0);
        cyc(1, 0, 8'hE3, 0, 0, 0);
        cyc(0, 0, 8'h00, 0, 0, 1);
        checks++;
        if (fifo_ovf !== 1'b1 || fifo_level !== 5'd16) begin
            errors++; $display("FAIL ovf_set_wins: ovf=%b level=%0d, want 1 16", fifo_ovf, fifo_level);
        end
        // write while full with simultaneous pop: write dropped, pop happens
        cyc(0, 0, 8'h00, 0, 0, 1);
        cyc(1, 0, 8'hE4, 0, 0, 0);
        cyc(1, 0, 8'hE5, 0, 0, 0);
        cyc(0, 0, 8'h00, 1, 0, 0);
        checks++;
        if (fifo_level !== 5'd15 || fifo_ovf !== 1'b1 || fifo_q !== 16'h0403 || fifo_full !== 1'b0) begin
            errors++; $display("FAIL full_pop: level=%0d ovf=%b q=%h full=%b, want 15 1 0403 0",
                               fifo_level, fifo_ovf, fifo_q, fifo_full);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1, 0, 8'(8'h40 + i), 0, 0, 0);
        cyc(1, 0, 8'h77, 0, 0, 0);
        cyc(0, 0, 8'h00, 0, 0, 1);
        checks++;
        if (fifo_level !== 5'd5) begin
            errors++; $display("FAIL flush_pre: level=%0d, want 5", fifo_level);
        end
        cyc(1, 0, 8'h99, 0, 1, 0);
        checks++;
        if (fifo_level !== 5'd0 || fifo_empty !== 1'b1) begin
            errors++; $display("FAIL flush: level=%0d empty=%b, want 0 1", fifo_level, fifo_empty);
        end
        cyc(1, 0, 8'h01, 0, 0, 0);
        cyc(1, 0, 8'h02, 0, 0, 0);
        cyc(0, 0, 8'h00, 0, 0, 0);
        checks++;
        if (fifo_level !== 5'd1 || fifo_q !== 16'h0201) begin
            errors++; $display("FAIL flush_clean: level=%0d q=%h, want 1 0201", fifo_level, fifo_q);
        end
        // flush on the edge a registered word would be written
        cyc(1, 0, 8'hA1, 0, 0, 0);
        cyc(1, 0, 8'hA2, 0, 0, 0);
        cyc(0, 0, 8'h00, 0, 1, 0);
        cyc(0, 0, 8'h00, 0, 0, 0);
        checks++;
        if (fifo_empty !== 1'b1 || fifo_level !== 5'd0) begin
            errors++; $display("FAIL flush_pending: empty=%b level=%0d, want 1 0", fifo_empty, fifo_level);
        end
    endtask

    task automatic test_msb_first();
        do_reset();
        cyc2(1, 8'hAA);
        cyc2(1, 8'hBB);
        cyc2(1, 8'hCC);
        cyc2(1, 8'hDD);
        cyc2(0, 8'h00);
        checks++;
        if (b_q !== 32'hAABBCCDD || b_level !== 5'd1) begin
            errors++; $display("FAIL msb_first: q=%h level=%0d, want aabbccdd 1", b_q, b_level);
        end
    endtask

    task automatic test_random();
        bit vld, sof, rd, fl, clr;
        int rdp;
        logic [15:0] exp_head;
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            if (i == 5000) begin
                cyc(1, 0, 8'h5A, 0, 0, 0);
                do_reset();
                checks++;
                if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || fifo_level !== 5'd0 || fifo_ovf !== 1'b0) begin
                    errors++; $display("FAIL random_reset: empty=%b full=%b level=%0d ovf=%b, want 1 0 0 0",
                                       fifo_empty, fifo_full, fifo_level, fifo_ovf);
                end
            end
            rdp = ((i / 700) % 2 == 1) ? 80 : 25;
            vld = ($urandom_range(0, 9) < 7);
            sof = vld && ($urandom_range(0, 19) == 0);
            rd  = ($urandom_range(0, 99) < rdp);
            fl  = ($urandom_range(0, 499) == 0);
            clr = ($urandom_range(0, 49) == 0);
            cyc(vld, sof, 8'($urandom), rd, fl, clr);
            exp_head = (mq.size() > 0) ? mq[0] : 16'h0000;
            checks++;
            if (fifo_level !== 5'(mq.size()) || fifo_empty !== (mq.size() == 0) ||
                fifo_full !== (mq.size() == 16) || fifo_ovf !== movf ||
                (mq.size() > 0 && fifo_q !== exp_head)) begin
                errors++;
                if (errors < 20)
                    $display("FAIL random cyc %0d: level %0d want %0d, q %h want %h, ovf %b want %b, empty %b full %b",
                             i, fifo_level, mq.size(), fifo_q, exp_head, fifo_ovf, movf, fifo_empty, fifo_full);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pack();
        test_empty_write_read();
        test_sof();
        test_overflow();
        test_flush();
        test_msb_first();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/inpfifo_pack.md
INPFIFO_PACK -- requirements
Module: inpfifo_pack

Interface
REQ-001 Parameter DIN_W, default 8, input lane width in bits.
REQ-002 Parameter LANES, default 2, input lanes packed per output word (2..8).
REQ-003 Parameter DEPTH, default 16, FIFO depth in words (power of 2, 4..1024).
REQ-004 Parameter MSB_FIRST, default 0: 0 means the first lane lands in bits [DIN_W-1:0]; 1 means the first lane lands in the top lane.
REQ-005 clk  in  1  single clock for input bus, packer and FIFO.
REQ-006 rst  in  1  reset, synchronous, active-low.
REQ-007 din  in  DIN_W  input lane data.
REQ-008 din_vld  in  1  lane valid; din is sampled only when high.
REQ-009 din_sof  in  1  start-of-frame; qualified by din_vld; forces this lane to lane 0.
REQ-010 flush  in  1  empties the FIFO and discards any partial word.
REQ-011 ovf_clr  in  1  clears the sticky overflow flag.
REQ-012 fifo_rd  in  1  read/pop request, active-high.
REQ-013 fifo_q  out  DIN_W*LANES  head word (first-word-fall-through).
REQ-014 fifo_empty  out  1  no words stored.
REQ-015 fifo_full  out  1  DEPTH words stored.
REQ-016 fifo_level  out  clog2(DEPTH)+1  stored word count.
REQ-017 fifo_ovf  out  1  sticky: a completed word was dropped.

Function
REQ-018 Lane counter 0..LANES-1: advances on each din_vld, wraps LANES-1 -> 0; holds when din_vld=0.
REQ-019 din_vld=1 with din_sof=1 stores din as lane 0 (counter -> 1), discards any partial word, and does not write it.
REQ-020 Lane k is placed at bits [k*DIN_W +: DIN_W] when MSB_FIRST=0, and at lane LANES-1-k when MSB_FIRST=1.
REQ-021 Word is complete when the lane LANES-1 beat is accepted at edge N; it is registered and written to memory at edge N+1; fifo_empty deasserts after edge N+1.
REQ-022 fifo_q = mem[rd_ptr] combinationally; value undefined (but stable) while fifo_empty=1.
REQ-023 fifo_rd with fifo_empty=0 pops at the edge; fifo_rd with fifo_empty=1 is ignored with no pointer or level change.
REQ-024 Simultaneous write and pop on a non-empty, non-full FIFO: level unchanged, both pointers advance.
REQ-025 Write while fifo_full=1 (even with simultaneous pop) is rejected: word dropped, fifo_ovf set at the same edge; the pop still proceeds.
REQ-026 Write while empty with simultaneous fifo_rd: write occurs, read is ignored, level becomes 1.
REQ-027 Pointers are clog2(DEPTH) bits and wrap modulo DEPTH; fifo_full = (level==DEPTH), fifo_empty = (level==0).
REQ-028 flush=1: at the edge, pointers, level and lane counter go to 0; the pending registered word is dropped; din in the same cycle is discarded; fifo_ovf is unaffected.
REQ-029 ovf_clr=1 clears fifo_ovf; if an overflow occurs in the same cycle, the set wins.
REQ-030 Priority: rst > flush > sof > normal operation.

Reset
REQ-031 With rst=0 at an edge: fifo_empty=1, fifo_full=0, fifo_level=0, fifo_ovf=0, lane counter=0, pending-write flag=0; memory contents are not reset.
REQ-032 Reset mid-word or mid-transfer discards all data; the first din_vld after release is lane 0.

Structure
REQ-033 Shared package inpfifo_pkg holds the clog2 function, lane-index type and default parameter constants.
REQ-034 Storage and pointers sit in one sub-module sync_fifo_fwft (params WIDTH, DEPTH); inpfifo_pack holds the packer and the overflow logic.

Verification
REQ-035 Defaults, din_vld=1 continuously, din=0x01,0x02,0x03,0x04 -> words 0x0201, 0x0403; first word visible 2 edges after the 0x02 beat.
REQ-036 MSB_FIRST=1, LANES=4, din=0xAA,0xBB,0xCC,0xDD -> fifo_q=0xAABBCCDD.
REQ-037 Defaults, 0x11 then 0x22 with din_sof -> partial 0x11 dropped; next lane 0x33 -> word 0x3322.
REQ-038 Fill 16 words with no reads, then complete word 17 -> fifo_full=1, level=16, fifo_ovf=1, head still word 1; ovf_clr -> fifo_ovf=0.
REQ-039 Level 5 plus a partial lane, flush -> next edge level=0, empty=1; next 2 lanes form a clean word.
REQ-040 Random din_vld/fifo_rd, 10k cycles, against a reference queue model -> data order exact, level tracks, no pop on empty; rst=0 mid-run -> all state returns to REQ-031 values.
